// File: rtl/rf_arb_pkg.sv
// Shared state encoding, default sizing and index-width helper for the register-file read arbiter.
package rf_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int AW_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Combinational winner selection: first candidate found scanning upward from start_i, wrapping.
module rr_pick
    import rf_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] excl_i,
    input  logic [IW-1:0]   start_i,
    output logic            valid_o,
    output logic [IW-1:0]   win_o
);

    logic [NREQ-1:0] cand;
    logic [IW:0]     j;
    logic            found;

    assign cand = req_i & ~excl_i;

    always_comb begin
        found = 1'b0;
        win_o = '0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, start_i} + (IW+1)'(k);
            if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
            if (!found && cand[j[IW-1:0]]) begin
                found = 1'b1;
                win_o = j[IW-1:0];
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shared register-file read port arbiter: IDLE -> GRANT (drive mux) -> RESP (strobe data).
// Define RF_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise lowest index wins.
module regfile_read_arbiter
    import rf_arb_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    parameter int  W    = W_DEF,
    parameter int  AW   = AW_DEF,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] raddr,
    output logic [AW-1:0]     rf_sel,
    input  logic [W-1:0]      rf_data,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      rdata,
    output logic              rvalid,
    output logic [IW-1:0]     rid
);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   rid_q, rid_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   sel_q, sel_d;
    logic [W-1:0]    rdata_q, rdata_d;

    logic [NREQ-1:0] excl;
    logic [IW-1:0]   start;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [AW-1:0]   pick_addr;

    // The requester just answered still holds req during RESP; keep it out of the next round.
    assign excl = (state_q == ST_RESP) ? (NREQ'(1) << rid_q) : '0;

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;

    assign start = ptr_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q != ST_GRANT && pick_vld)
            ptr_d = (pick == IW'(NREQ-1)) ? '0 : pick + IW'(1);
    end
`else
    assign start = '0;
`endif

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i   (req),
        .excl_i  (excl),
        .start_i (start),
        .valid_o (pick_vld),
        .win_o   (pick)
    );

    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick == IW'(i)) pick_addr = raddr[i*AW +: AW];
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        rid_d   = rid_q;
        rdata_d = rdata_q;
        gnt_d   = '0;
        sel_d   = '0;
        case (state_q)
            ST_GRANT: begin
                rdata_d = rf_data;
                rid_d   = win_q;
                state_d = ST_RESP;
            end
            default: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    win_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    sel_d   = pick_addr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            rid_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rid_q   <= rid_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

    assign gnt    = gnt_q;
    assign rf_sel = sel_q;
    assign rdata  = rdata_q;
    assign rvalid = (state_q == ST_RESP);
    assign rid    = rid_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter; register file modelled as reg[i] = 0xA0 + i.
module tb_regfile_read_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int AW   = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] raddr;
    logic [AW-1:0]     rf_sel;
    logic [W-1:0]      rf_data;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      rdata;
    logic              rvalid;
    logic [1:0]        rid;

    logic [W-1:0] rf_mem [8];

    int n_cmp = 0;
    int n_bad = 0;

    regfile_read_arbiter #(.NREQ(NREQ), .W(W), .AW(AW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req),
        .raddr   (raddr),
        .rf_sel  (rf_sel),
        .rf_data (rf_data),
        .gnt     (gnt),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rid     (rid)
    );

    assign rf_data = rf_mem[rf_sel];

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        raddr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        req   = '0;
        raddr = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = 8'hA0 + 8'(i);
        RST   = 1'b1;
        req   = '0;
        raddr = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_gnt",    32'(gnt),    32'h0);
        chk("rst_sel",    32'(rf_sel), 32'h0);
        chk("rst_rdata",  32'(rdata),  32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rid",    32'(rid),    32'h0);
        RST = 1'b0;

        // single request
        set_addr(0, 3'd5);
        req = 4'b0001;
        step();
        chk("single_gnt",    32'(gnt),    32'h1);
        chk("single_sel",    32'(rf_sel), 32'h5);
        chk("single_novld",  32'(rvalid), 32'h0);
        step();
        chk("single_rvalid", 32'(rvalid), 32'h1);
        chk("single_rid",    32'(rid),    32'h0);
        chk("single_rdata",  32'(rdata),  32'hA5);
        chk("single_gnt0",   32'(gnt),    32'h0);
        chk("single_sel0",   32'(rf_sel), 32'h0);
        req = '0;
        step();
        chk("single_idle_vld",  32'(rvalid), 32'h0);
        chk("single_hold_data", 32'(rdata),  32'hA5);
        chk("single_idle_gnt",  32'(gnt),    32'h0);

        // full contention, each requester drops after its response
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(i + 1));
        req = 4'b1111;
        step();
        for (int k = 0; k < NREQ; k++) begin
            chk($sformatf("cont%0d_gnt", k),  32'(gnt),    32'(1) << k);
            chk($sformatf("cont%0d_sel", k),  32'(rf_sel), 32'(k + 1));
            step();
            chk($sformatf("cont%0d_vld", k),  32'(rvalid), 32'h1);
            chk($sformatf("cont%0d_rid", k),  32'(rid),    32'(k));
            chk($sformatf("cont%0d_data", k), 32'(rdata),  32'hA1 + 32'(k));
            req[k] = 1'b0;
            step();
        end
        chk("cont_end_vld", 32'(rvalid), 32'h0);
        chk("cont_end_gnt", 32'(gnt),    32'h0);

`ifdef RF_ARB_ROUND_ROBIN_EN
        // serve requester 2 to leave pointer at 3, then 3 must beat 0
        do_reset();
        req = 4'b0100;
        step();
        step();
        req = '0;
        step();
        set_addr(0, 3'd5);
        set_addr(3, 3'd6);
        req = 4'b1001;
        step();
        chk("wrap_gnt3",  32'(gnt),    32'h8);
        chk("wrap_sel3",  32'(rf_sel), 32'h6);
        step();
        chk("wrap_rid3",  32'(rid),    32'h3);
        chk("wrap_data3", 32'(rdata),  32'hA6);
        req[3] = 1'b0;
        step();
        chk("wrap_gnt0",  32'(gnt),    32'h1);
        chk("wrap_sel0",  32'(rf_sel), 32'h5);
        step();
        chk("wrap_rid0",  32'(rid),    32'h0);
        chk("wrap_data0", 32'(rdata),  32'hA5);
        req = '0;
        step();
`else
        // fixed priority: 1 before 3
        do_reset();
        set_addr(1, 3'd6);
        set_addr(3, 3'd7);
        req = 4'b1010;
        step();
        chk("fix_gnt1",  32'(gnt),    32'h2);
        chk("fix_sel1",  32'(rf_sel), 32'h6);
        step();
        chk("fix_rid1",  32'(rid),    32'h1);
        chk("fix_data1", 32'(rdata),  32'hA6);
        req[1] = 1'b0;
        step();
        chk("fix_gnt3",  32'(gnt),    32'h8);
        chk("fix_sel3",  32'(rf_sel), 32'h7);
        step();
        chk("fix_rid3",  32'(rid),    32'h3);
        chk("fix_data3", 32'(rdata),  32'hA7);
        req = '0;
        step();
`endif

        // reset while in GRANT
        set_addr(2, 3'd3);
        req = 4'b0100;
        step();
        chk("rg_gnt_pre", 32'(gnt), 32'h4);
        RST = 1'b1;
        #1;
        chk("rg_gnt",    32'(gnt),    32'h0);
        chk("rg_sel",    32'(rf_sel), 32'h0);
        chk("rg_rdata",  32'(rdata),  32'h0);
        chk("rg_rvalid", 32'(rvalid), 32'h0);
        chk("rg_rid",    32'(rid),    32'h0);
        @(negedge CLK);
        chk("rg_hold_vld", 32'(rvalid), 32'h0);
        @(negedge CLK);
        chk("rg_hold_gnt", 32'(gnt), 32'h0);
        RST = 1'b0;
        step();
        chk("rg_post_gnt",  32'(gnt),    32'h4);
        chk("rg_post_sel",  32'(rf_sel), 32'h3);
        step();
        chk("rg_post_vld",  32'(rvalid), 32'h1);
        chk("rg_post_rid",  32'(rid),    32'h2);
        chk("rg_post_data", 32'(rdata),  32'hA3);
        req = '0;
        step();

        // raddr changes while granted must not disturb the read
        set_addr(0, 3'd5);
        req = 4'b0001;
        step();
        chk("chg_sel_pre", 32'(rf_sel), 32'h5);
        set_addr(0, 3'd2);
        #1;
        chk("chg_sel_mid", 32'(rf_sel), 32'h5);
        step();
        chk("chg_vld",  32'(rvalid), 32'h1);
        chk("chg_rid",  32'(rid),    32'h0);
        chk("chg_data", 32'(rdata),  32'hA5);
        req = '0;
        step();
        chk("chg_end_vld", 32'(rvalid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
